// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/execute/mem/wb control FSM for the RV32I core
// Optional macro SEQ_ILLEGAL_TRAP_EN: unknown opcodes halt the core instead of executing as no-ops.
module core_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       take_branch,
  input  logic       instr_ready,
  input  logic       data_ready,
  output logic       instr_req,
  output logic       data_req,
  output logic       data_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_a_pc,
  output logic       alu_b_imm,
  output logic       instr_done,
  output logic       halted,
  output logic       bus_error
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [TIMEOUT_W:0] LIMIT = (TIMEOUT_W + 1)'(MEM_TIMEOUT);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 err_q;
  logic                 waiting;
  logic                 timeout;

  // A ready in the limit cycle clears waiting, so ready always beats the timeout.
  always_comb begin
    waiting = (state == S_FETCH && !instr_ready) || (state == S_MEM && !data_ready);
    timeout = TIMEOUT_EN && waiting && (({1'b0, wait_cnt} + 1'b1) == LIMIT);
  end

  always_comb begin
    next_state = state;
    instr_req  = 1'b0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 2'b00;
    reg_write  = 1'b0;
    wb_sel     = 2'b00;
    alu_a_pc   = 1'b0;
    alu_b_imm  = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    bus_error  = err_q;
    case (state)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_ready) begin
          ir_write   = 1'b1;
          next_state = S_DECODE;
        end else if (timeout) begin
          next_state = S_HALT;
        end
      end
      S_DECODE: next_state = S_EXECUTE;
      S_EXECUTE: begin
        next_state = S_FETCH;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        case (opcode)
          OP_R:     reg_write = 1'b1;
          OP_I:     begin reg_write = 1'b1; alu_b_imm = 1'b1; end
          OP_LUI:   begin reg_write = 1'b1; wb_sel = 2'b11; end
          OP_AUIPC: begin reg_write = 1'b1; alu_a_pc = 1'b1; alu_b_imm = 1'b1; end
          OP_JAL:   begin reg_write = 1'b1; wb_sel = 2'b10; pc_sel = 2'b10; end
          OP_JALR:  begin reg_write = 1'b1; wb_sel = 2'b10; pc_sel = 2'b11; end
          OP_BRANCH: pc_sel = take_branch ? 2'b01 : 2'b00;
          OP_FENCE: pc_sel = 2'b00;
          OP_LOAD, OP_STORE: begin
            pc_write   = 1'b0;
            instr_done = 1'b0;
            alu_b_imm  = 1'b1;
            next_state = S_MEM;
          end
          OP_SYSTEM: begin
            pc_write   = 1'b0;
            instr_done = 1'b0;
            next_state = S_HALT;
          end
          default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            pc_write   = 1'b0;
            instr_done = 1'b0;
            next_state = S_HALT;
`else
            pc_sel = 2'b00;
`endif
          end
        endcase
      end
      S_MEM: begin
        data_req  = 1'b1;
        alu_b_imm = 1'b1;
        data_we   = (opcode == OP_STORE);
        if (data_ready) begin
          if (opcode == OP_STORE) begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end else if (timeout) begin
          next_state = S_HALT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        wb_sel     = 2'b01;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: next_state = S_FETCH;
    endcase
    if (reset) begin
      next_state = S_FETCH;
      instr_req  = 1'b0;
      data_req   = 1'b0;
      data_we    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = 2'b00;
      reg_write  = 1'b0;
      wb_sel     = 2'b00;
      alu_a_pc   = 1'b0;
      alu_b_imm  = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
      bus_error  = 1'b0;
    end
  end

  // The counter is zero whenever we are not waiting, so it is clear on entry to FETCH/MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      if (timeout) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized self-checking bench for core_sequencer against a per-instruction model
module tb_core_sequencer;

  localparam int TO = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic clk = 1'b0;
  logic reset, take_branch, instr_ready, data_ready;
  logic [6:0] opcode;
  logic instr_req, data_req, data_we, ir_write, pc_write, reg_write;
  logic alu_a_pc, alu_b_imm, instr_done, halted, bus_error;
  logic [1:0] pc_sel, wb_sel;

  typedef struct packed {
    logic       instr_req;
    logic       data_req;
    logic       data_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_a_pc;
    logic       alu_b_imm;
    logic       instr_done;
    logic       halted;
    logic       bus_error;
  } outs_t;

  outs_t got;
  assign got = {instr_req, data_req, data_we, ir_write, pc_write, pc_sel, reg_write,
                wb_sel, alu_a_pc, alu_b_imm, instr_done, halted, bus_error};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_sequencer #(.MEM_TIMEOUT(TO), .TIMEOUT_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .take_branch(take_branch),
    .instr_ready(instr_ready), .data_ready(data_ready),
    .instr_req(instr_req), .data_req(data_req), .data_we(data_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_sel(pc_sel), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm), .instr_done(instr_done),
    .halted(halted), .bus_error(bus_error)
  );

  task automatic check(input string tag, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (time %0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // One clock: drive inputs just after the edge, compare at the falling edge.
  task automatic cycle(input logic ir, input logic dr, input logic tbr, input outs_t exp,
                       input string tag);
    instr_ready = ir;
    data_ready  = dr;
    take_branch = tbr;
    @(negedge clk);
    check(tag, got, exp);
    @(posedge clk);
    #1;
  endtask

  // 0: completes in EXECUTE, 1: goes to memory, 2: halts
  function automatic int exec_kind(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return 1;
      OP_SYSTEM: return 2;
      OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_FENCE: return 0;
`ifdef SEQ_ILLEGAL_TRAP_EN
      default: return 2;
`else
      default: return 0;
`endif
    endcase
  endfunction

  function automatic outs_t exec_outs(input logic [6:0] op, input logic tbv);
    outs_t e = '0;
    if (exec_kind(op) == 0) begin
      e.pc_write   = 1'b1;
      e.instr_done = 1'b1;
    end
    if (exec_kind(op) == 1) e.alu_b_imm = 1'b1;
    case (op)
      OP_R:      e.reg_write = 1'b1;
      OP_I:      begin e.reg_write = 1'b1; e.alu_b_imm = 1'b1; end
      OP_LUI:    begin e.reg_write = 1'b1; e.wb_sel = 2'b11; end
      OP_AUIPC:  begin e.reg_write = 1'b1; e.alu_a_pc = 1'b1; e.alu_b_imm = 1'b1; end
      OP_JAL:    begin e.reg_write = 1'b1; e.wb_sel = 2'b10; e.pc_sel = 2'b10; end
      OP_JALR:   begin e.reg_write = 1'b1; e.wb_sel = 2'b10; e.pc_sel = 2'b11; end
      OP_BRANCH: e.pc_sel = tbv ? 2'b01 : 2'b00;
      default:   ;
    endcase
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    cycle(rnd(), rnd(), rnd(), '0, "reset_outs");
    cycle(rnd(), rnd(), rnd(), '0, "reset_outs");
    reset = 1'b0;
  endtask

  task automatic front_end(input logic [6:0] op, input int fd, input logic tbv);
    outs_t e;
    opcode = op;
    for (int i = 0; i < fd; i++) begin
      e = '0; e.instr_req = 1'b1;
      cycle(1'b0, rnd(), rnd(), e, "fetch_wait");
    end
    e = '0; e.instr_req = 1'b1; e.ir_write = 1'b1;
    cycle(1'b1, rnd(), rnd(), e, "fetch");
    cycle(rnd(), rnd(), rnd(), '0, "decode");
    cycle(rnd(), rnd(), tbv, exec_outs(op, tbv), "execute");
  endtask

  // br: 0/1 forces take_branch in EXECUTE, 2 randomizes it
  task automatic run_instr(input logic [6:0] op, input int fd, input int md, input int br,
                           output bit halted_out);
    outs_t e;
    logic  tbv;
    bit    st;
    tbv = (br == 2) ? rnd() : br[0];
    front_end(op, fd, tbv);
    halted_out = 1'b0;
    if (exec_kind(op) == 2) begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.halted = 1'b1;
        cycle(1'b1, rnd(), rnd(), e, "halt");
      end
      halted_out = 1'b1;
    end else if (exec_kind(op) == 1) begin
      st = (op == OP_STORE);
      e = '0; e.data_req = 1'b1; e.data_we = st; e.alu_b_imm = 1'b1;
      for (int i = 0; i < md; i++) cycle(rnd(), 1'b0, rnd(), e, "mem_wait");
      if (st) begin e.pc_write = 1'b1; e.instr_done = 1'b1; end
      cycle(rnd(), 1'b1, rnd(), e, "mem");
      if (!st) begin
        e = '0; e.reg_write = 1'b1; e.wb_sel = 2'b01; e.pc_write = 1'b1; e.instr_done = 1'b1;
        cycle(rnd(), rnd(), rnd(), e, "wb");
      end
    end
  endtask

  logic [6:0] pool [14];
  bit h;
  outs_t e;

  initial begin
    pool = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_FENCE,
             OP_LOAD, OP_STORE, OP_SYSTEM, 7'b1111111, 7'b0101011, 7'b0110000};
    reset = 1'b1; opcode = '0; instr_ready = 1'b0; data_ready = 1'b0; take_branch = 1'b0;
    @(posedge clk); #1;
    do_reset();

    run_instr(OP_R, 0, 0, 2, h);
    run_instr(OP_BRANCH, 0, 0, 1, h);
    run_instr(OP_BRANCH, 1, 0, 0, h);
    run_instr(OP_LOAD, 0, 3, 2, h);
    run_instr(OP_STORE, 2, TO - 1, 2, h);

    // store with data_ready stuck low times out into HALT with bus_error
    front_end(OP_STORE, 0, 1'b0);
    e = '0; e.data_req = 1'b1; e.data_we = 1'b1; e.alu_b_imm = 1'b1;
    for (int i = 0; i < TO; i++) cycle(rnd(), 1'b0, rnd(), e, "store_timeout_wait");
    e = '0; e.halted = 1'b1; e.bus_error = 1'b1;
    for (int i = 0; i < 4; i++) cycle(i[0], 1'b0, rnd(), e, "store_timeout_halt");
    do_reset();

    // fetch timeout
    e = '0; e.instr_req = 1'b1;
    for (int i = 0; i < TO; i++) cycle(1'b0, rnd(), rnd(), e, "fetch_timeout_wait");
    e = '0; e.halted = 1'b1; e.bus_error = 1'b1;
    cycle(1'b1, rnd(), rnd(), e, "fetch_timeout_halt");
    do_reset();

    run_instr(OP_SYSTEM, 0, 0, 2, h);
    if (h) do_reset();
    run_instr(7'b1111111, 0, 0, 2, h);
    if (h) do_reset();

    // reset asserted mid-MEM
    front_end(OP_LOAD, 0, 1'b0);
    e = '0; e.data_req = 1'b1; e.alu_b_imm = 1'b1;
    cycle(rnd(), 1'b0, rnd(), e, "mem_before_reset");
    reset = 1'b1;
    cycle(rnd(), rnd(), rnd(), '0, "reset_in_mem");
    reset = 1'b0;
    run_instr(OP_I, 0, 0, 2, h);

    for (int n = 0; n < 80; n++) begin
      run_instr(pool[$urandom_range(13, 0)], $urandom_range(TO - 1, 0),
                $urandom_range(TO - 1, 0), 2, h);
      if (h) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
